// File: rtl/mips_mem_pkg.sv
// mips_mem_pkg: shared types and widths for the multicycle datapath memory port
package mips_mem_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} memState;
  localparam int MEM_LAT_MAX = 15;
  localparam int CNT_W = $clog2(MEM_LAT_MAX + 1);
  localparam int MEM_DATA_W = 32;
  localparam int MEM_ADDR_W = 32;
endpackage

// File: rtl/mem_wait_unit_if.sv
// mem_wait_unit_if: memory request bus (addr/wdata/memread/memwrite in, rdata/ready/addr_err back)
interface mem_wait_unit_if
  import mips_mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W
);
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic [DATA_W-1:0] rdata;
  logic memread;
  logic memwrite;
  logic ready;
  logic addr_err;
  modport master(output addr, wdata, memread, memwrite, input rdata, ready, addr_err);
  modport slave(input addr, wdata, memread, memwrite, output rdata, ready, addr_err);
endinterface

// File: rtl/mem_array.sv
// mem_array: single-port synchronous RAM, DEPTH x DATA_W, registered read with enable and clear
module mem_array #(
  parameter int DATA_W = 32,
  parameter int DEPTH = 1024,
  parameter int IDX_W = $clog2(DEPTH),
  parameter string INIT_FILE = ""
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic              re,
  input  logic              clr,
  input  logic [IDX_W-1:0]  idx,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);
  logic [DATA_W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[idx] <= wdata;
  always_ff @(posedge clk)
    if (rst || clr) rdata <= '0;
    else if (re) rdata <= mem[idx];
endmodule

// File: rtl/mem_wait_unit.sv
// mem_wait_unit: unified memory with fixed access latency and a one-cycle ready pulse
// clk/rst: clock and synchronous active-high reset; bus: slave side of mem_wait_unit_if
module mem_wait_unit
  import mips_mem_pkg::*;
#(
  parameter int DATA_W = MEM_DATA_W,
  parameter int ADDR_W = MEM_ADDR_W,
  parameter int DEPTH = 1024,
  parameter int LATENCY = 2,
  parameter string INIT_FILE = "mem.hex"
) (
  input logic clk,
  input logic rst,
  mem_wait_unit_if.slave bus
);
  localparam int IDX_W = $clog2(DEPTH);
  memState state, stateNext;
  logic [CNT_W-1:0] cnt;
  logic [ADDR_W-3:0] reqIdx, opIdx;
  logic [DATA_W-1:0] reqData, opData;
  logic reqRd, reqWr, reqErr, opRd, opWr, opErr, req, fin, ramWe, ramRe, ramClr;
  // In IDLE the live inputs are used so a LATENCY=1 access can complete on its acceptance edge
  always_comb begin
    req = bus.memread | bus.memwrite;
    opIdx = state == IDLE ? bus.addr[ADDR_W-1:2] : reqIdx;
    opData = state == IDLE ? bus.wdata : reqData;
    opRd = state == IDLE ? bus.memread : reqRd;
    opWr = state == IDLE ? bus.memwrite : reqWr;
    opErr = opIdx >= (ADDR_W-2)'(DEPTH);
  end
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= stateNext;
  always_comb
    stateNext = state == IDLE ? (req ? (LATENCY == 1 ? DONE : BUSY) : IDLE)
              : state == BUSY ? (cnt == 0 ? DONE : BUSY) : IDLE;
  // fin marks the edge entering DONE; reset there aborts the commit
  always_comb begin
    fin = !rst && stateNext == DONE;
    bus.ready = state == DONE;
    bus.addr_err = state == DONE && reqErr;
    ramWe = fin && opWr && !opErr;
    ramRe = fin && opRd && !opWr && !opErr;
    ramClr = fin && opRd && !opWr && opErr;
  end
  always_ff @(posedge clk)
    if (rst) cnt <= '0;
    else if (state == IDLE && req) begin
      cnt <= CNT_W'(LATENCY - 1);
      reqIdx <= opIdx;
      reqData <= opData;
      reqRd <= opRd;
      reqWr <= opWr;
      reqErr <= opErr;
    end else if (state == BUSY && cnt != 0) cnt <= cnt - 1'b1;
  mem_array #(
    .DATA_W(DATA_W),
    .DEPTH(DEPTH),
    .IDX_W(IDX_W),
    .INIT_FILE(INIT_FILE)
  ) array (
    .clk(clk),
    .rst(rst),
    .we(ramWe),
    .re(ramRe),
    .clr(ramClr),
    .idx(opIdx[IDX_W-1:0]),
    .wdata(opData),
    .rdata(bus.rdata)
  );
endmodule

// File: tb/tb_mem_wait_unit.sv
// tb_mem_wait_unit: vector table, hand sequences and randomized model check of mem_wait_unit
module tb_mem_wait_unit;
  localparam int DEPTH = 1024;
  localparam int LAT = 2;
  typedef struct {
    logic rd;
    logic wr;
    logic [31:0] a;
    logic [31:0] d;
    logic [31:0] expR;
    logic expE;
  } vecT;
  logic clk = 1'b0;
  logic rst;
  int total = 0;
  int passed = 0;
  mem_wait_unit_if #(.DATA_W(32), .ADDR_W(32)) bus ();
  mem_wait_unit #(
    .DATA_W(32),
    .ADDR_W(32),
    .DEPTH(DEPTH),
    .LATENCY(LAT),
    .INIT_FILE("")
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %h expected %h", n, got, exp);
  endtask
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d,
                        input bit scr, output int lat, output logic [31:0] rdv, output logic err);
    bus.memread = rd;
    bus.memwrite = wr;
    bus.addr = a;
    bus.wdata = d;
    lat = 0;
    rdv = '0;
    err = 1'b0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      if (i == 1 && scr) begin
        bus.addr = $urandom;
        bus.wdata = $urandom;
        bus.memread = 1'($urandom);
        bus.memwrite = 1'($urandom);
      end
      if (bus.ready) begin
        lat = i;
        rdv = bus.rdata;
        err = bus.addr_err;
        break;
      end
    end
    bus.memread = 1'b0;
    bus.memwrite = 1'b0;
    @(posedge clk);
    #1;
    chk("readyPulse", 32'(bus.ready), 32'd0);
    chk("rdataHold", bus.rdata, rdv);
  endtask
  vecT vecs [12];
  logic [31:0] model [int];
  logic [31:0] modelR, rdv;
  logic err;
  int lat, w, n;
  initial begin
    vecs[0]  = '{1'b0, 1'b1, 32'h8,    32'h1234ABCD, 32'h0,        1'b0};
    vecs[1]  = '{1'b1, 1'b0, 32'h8,    32'h0,        32'h1234ABCD, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 32'hB,    32'h0,        32'h1234ABCD, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 32'h10,   32'hDEADBEEF, 32'h1234ABCD, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 32'h4,    32'h55,       32'hDEADBEEF, 1'b0};
    vecs[6]  = '{1'b1, 1'b0, 32'h4,    32'h0,        32'h55,       1'b0};
    vecs[7]  = '{1'b0, 1'b1, 32'h0,    32'hA5A5A5A5, 32'h55,       1'b0};
    vecs[8]  = '{1'b1, 1'b0, 32'h1000, 32'h0,        32'h0,        1'b1};
    vecs[9]  = '{1'b0, 1'b1, 32'h1000, 32'h77,       32'h0,        1'b1};
    vecs[10] = '{1'b1, 1'b0, 32'h0,    32'h0,        32'hA5A5A5A5, 1'b0};
    vecs[11] = '{1'b1, 1'b0, 32'h8,    32'h0,        32'h1234ABCD, 1'b0};
    rst = 1'b1;
    bus.memread = 1'b0;
    bus.memwrite = 1'b0;
    bus.addr = '0;
    bus.wdata = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("idleReady", 32'(bus.ready), 32'd0);
      chk("idleRdata", bus.rdata, 32'd0);
      chk("idleErr", 32'(bus.addr_err), 32'd0);
    end
    foreach (vecs[i]) begin
      access(vecs[i].rd, vecs[i].wr, vecs[i].a, vecs[i].d, 1'b0, lat, rdv, err);
      chk($sformatf("vecLat%0d", i), lat, LAT + 1);
      chk($sformatf("vecRdata%0d", i), rdv, vecs[i].expR);
      chk($sformatf("vecErr%0d", i), 32'(err), 32'(vecs[i].expE));
    end
    bus.memread = 1'b1;
    bus.addr = 32'h10;
    n = 0;
    for (int i = 1; i <= 40 && n < 2; i++) begin
      @(posedge clk);
      #1;
      if (bus.ready) begin
        chk($sformatf("heldReqAt%0d", n), i, n == 0 ? LAT + 1 : 2 * LAT + 3);
        chk("heldReqRdata", bus.rdata, 32'hDEADBEEF);
        n++;
      end
    end
    chk("heldReqCount", n, 2);
    bus.memread = 1'b0;
    @(posedge clk);
    #1;
    access(1'b0, 1'b1, 32'h20, 32'h11111111, 1'b0, lat, rdv, err);
    chk("preWrLat", lat, LAT + 1);
    bus.memwrite = 1'b1;
    bus.addr = 32'h20;
    bus.wdata = 32'h22222222;
    repeat (LAT) @(posedge clk);
    #1;
    rst = 1'b1;
    bus.memwrite = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("rstReady", 32'(bus.ready), 32'd0);
    chk("rstRdata", bus.rdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rstNoReady", 32'(bus.ready), 32'd0);
    end
    access(1'b1, 1'b0, 32'h20, 32'h0, 1'b0, lat, rdv, err);
    chk("rstReadLat", lat, LAT + 1);
    chk("rstReadData", rdv, 32'h11111111);
    modelR = 32'h11111111;
    for (int i = 0; i < 16; i++) begin
      model[i] = $urandom;
      access(1'b0, 1'b1, 32'(i * 4), model[i], 1'b1, lat, rdv, err);
      chk("initLat", lat, LAT + 1);
      chk("initRdata", rdv, modelR);
    end
    for (int k = 0; k < 150; k++) begin
      logic [1:0] op;
      logic [31:0] d;
      op = 2'($urandom_range(1, 3));
      w = ($urandom % 8 == 0) ? DEPTH + int'($urandom % 64) : int'($urandom % 16);
      d = $urandom;
      if (op[1]) begin
        if (w < DEPTH) model[w] = d;
      end else modelR = w < DEPTH ? model[w] : 32'h0;
      access(op[0], op[1], 32'(w * 4) | 32'($urandom % 4), d, 1'b1, lat, rdv, err);
      chk("rndLat", lat, LAT + 1);
      chk("rndRdata", rdv, modelR);
      chk("rndErr", 32'(err), 32'(w >= DEPTH));
    end
    for (int i = 0; i < 16; i++) begin
      access(1'b1, 1'b0, 32'(i * 4), 32'h0, 1'b0, lat, rdv, err);
      chk("finalRead", rdv, model[i]);
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
